// File: rtl/usb_stream_rx.sv
// FX2 slave-FIFO OUT-endpoint drain into a local first-word-fall-through FIFO.
// Optional received-word counter built only when USB_STREAM_RX_CNT_EN is defined.
module usb_stream_rx #(
  parameter int          DEPTH   = 16,
  parameter logic [1:0]  EP_ADDR = 2'b00
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST,
  input  logic        ENABLE,
  output logic [1:0]  USB_STREAM_FIFOADDR,
  output logic        USB_STREAM_SLOE_n,
  output logic        USB_STREAM_SLRD_n,
  input  logic [15:0] USB_STREAM_DATA_IN,
  input  logic [2:0]  USB_STREAM_FLAGS_N,
  input  logic        FIFO_READ,
  output logic        FIFO_EMPTY,
  output logic        FIFO_FULL,
  output logic [15:0] FIFO_DATA,
  output logic [15:0] WORD_CNT
);

  // state   | meaning
  // IDLE    | bus released, SLOE_n/SLRD_n high
  // WAIT    | SLOE_n low, waiting for endpoint data and a free local slot
  // READ    | SLRD_n low, word captured at the closing edge
  // HOLD    | one cycle for the FX2 empty flag to settle

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_READ, ST_HOLD} state_t;

  state_t          state;
  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, rd_ptr_n;
  logic [AW:0]     count, count_pop, count_n;
  logic            push, pop;
  logic [15:0]     head_n;
  logic            unused_flags;

  assign unused_flags = ^USB_STREAM_FLAGS_N[2:1];

  always_comb begin
    push      = (state == ST_READ);
    pop       = FIFO_READ && (count != '0);
    rd_ptr_n  = pop ? rd_ptr + AW'(1) : rd_ptr;
    count_pop = pop ? count - (AW+1)'(1) : count;
    count_n   = push ? count_pop + (AW+1)'(1) : count_pop;
    // When the FIFO would otherwise be empty, the word being captured is the new head.
    head_n    = (push && count_pop == '0) ? USB_STREAM_DATA_IN : mem[rd_ptr_n];
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state               <= ST_IDLE;
      USB_STREAM_SLOE_n   <= 1'b1;
      USB_STREAM_SLRD_n   <= 1'b1;
      USB_STREAM_FIFOADDR <= EP_ADDR;
    end else begin
      USB_STREAM_FIFOADDR <= EP_ADDR;
      case (state)
        ST_IDLE: begin
          if (ENABLE) begin
            state             <= ST_WAIT;
            USB_STREAM_SLOE_n <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (!ENABLE) begin
            state             <= ST_IDLE;
            USB_STREAM_SLOE_n <= 1'b1;
          end else if (USB_STREAM_FLAGS_N[0] && count < (AW+1)'(DEPTH)) begin
            state             <= ST_READ;
            USB_STREAM_SLRD_n <= 1'b0;
          end
        end
        ST_READ: begin
          state             <= ST_HOLD;
          USB_STREAM_SLRD_n <= 1'b1;
        end
        ST_HOLD: state <= ST_WAIT;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (push) mem[wr_ptr] <= USB_STREAM_DATA_IN;
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      FIFO_EMPTY <= 1'b1;
      FIFO_FULL  <= 1'b0;
      FIFO_DATA  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr     <= rd_ptr_n;
      count      <= count_n;
      FIFO_EMPTY <= (count_n == '0);
      FIFO_FULL  <= (count_n == (AW+1)'(DEPTH));
      if (push || pop) FIFO_DATA <= head_n;
    end
  end

`ifdef USB_STREAM_RX_CNT_EN
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST)   WORD_CNT <= '0;
    else if (push) WORD_CNT <= WORD_CNT + 16'(1);
  end
`else
  assign WORD_CNT = '0;
`endif

endmodule
